// File: rtl/instruction_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// instruction_sequencer_pkg
// Shared definitions for the instruction sequencer: opcode class constants,
// the NOP operator word, instruction field positions, FSM state encoding and
// small decode helpers.
// -----------------------------------------------------------------------------
package instruction_sequencer_pkg;

    // Opcode classes live in operator[15:12] (instruction bits [31:28]).
    localparam logic [3:0] ALU_OP    = 4'h1;
    localparam logic [3:0] BR_OP     = 4'hB;
    localparam logic [3:0] CALL_OP   = 4'hC;
    localparam logic [3:0] RET_OP    = 4'hD;
    localparam logic [3:0] HALT_OP   = 4'hE;
    localparam logic [3:0] NOP_CLASS = 4'hF;

    // Operator driven to the ALU stage whenever nothing is being issued.
    localparam logic [15:0] NOP_OP = 16'hF000;

    // Instruction word layout.
    localparam int OPERATOR_MSB = 31;
    localparam int OPERATOR_LSB = 16;
    localparam int OPERAND_MSB  = 15;
    localparam int OPERAND_LSB  = 0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_ISSUE  = 3'd3,
        ST_HALTED = 3'd4
    } seq_state_e;

    function automatic logic [15:0] instr_operator(input logic [31:0] word);
        return word[OPERATOR_MSB:OPERATOR_LSB];
    endfunction

    function automatic logic [15:0] instr_operand(input logic [31:0] word);
        return word[OPERAND_MSB:OPERAND_LSB];
    endfunction

    function automatic logic [3:0] instr_class(input logic [31:0] word);
        return word[OPERATOR_MSB:OPERATOR_MSB-3];
    endfunction

    // A zero mask means "branch always"; otherwise any selected flag set.
    function automatic logic branch_taken(input logic [3:0] mask,
                                          input logic [3:0] flags);
        return (mask == 4'h0) || ((flags & mask) != 4'h0);
    endfunction

endpackage

// File: rtl/instruction_sequencer_return_stack.sv
// -----------------------------------------------------------------------------
// seq_return_stack
// LIFO of return addresses for call/return instructions.
// Ports:
//   clk, reset (async, active-low)
//   clear      - synchronous empty (restart)
//   push/pop   - ignored when full/empty respectively
//   push_data  - address pushed
//   top_data   - most recently pushed entry (valid when !empty)
//   full/empty - occupancy status
// -----------------------------------------------------------------------------
module seq_return_stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top_data,
    output logic             full,
    output logic             empty
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [CW-1:0]    count_q, count_d;
    logic [IW-1:0]    wr_idx, rd_idx;

    assign wr_idx   = IW'(count_q);
    assign rd_idx   = IW'(count_q - 1'b1);
    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign top_data = mem_q[rd_idx];

    always_comb begin
        mem_d   = mem_q;
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (push && !full) begin
            mem_d[wr_idx] = push_data;
            count_d       = count_q + 1'b1;
        end else if (pop && !empty) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

endmodule

// File: rtl/instruction_sequencer.sv
// -----------------------------------------------------------------------------
// instruction_sequencer
// Fetches 32-bit instruction words from program memory and issues one
// operator/operand pair per instruction to the ALU/register stage. Handles
// NOP, halt, conditional branch and (optionally) call/return.
//
// Optional feature macro: SEQ_CALL_STACK_EN enables the return stack and the
// sticky fault flag. Without it, call/return decode as NOP and fault is 0.
//
// Ports:
//   clk, reset (async, active-low), start (restart pulse)
//   mem_req/mem_addr/mem_ack/mem_rdata - program memory fetch
//     (mem_req held with a stable mem_addr until mem_ack; mem_rdata is
//      captured in the same cycle mem_ack is high)
//   operator/operand/issue_valid      - to the ALU/register stage
//   alu_flags                         - branch condition inputs
//   pc, busy, halted, fault           - status
//   state_dbg                         - current FSM state
// -----------------------------------------------------------------------------
module instruction_sequencer
    import instruction_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int START_ADDR  = 0,
    parameter int STACK_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [31:0]           mem_rdata,
    output logic [15:0]           operator,
    output logic [15:0]           operand,
    output logic                  issue_valid,
    input  logic [3:0]            alu_flags,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  busy,
    output logic                  halted,
    output logic                  fault,
    output logic [2:0]            state_dbg
);
    localparam logic [ADDR_WIDTH-1:0] START_PC = START_ADDR[ADDR_WIDTH-1:0];

    seq_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [31:0]           instr_q, instr_d;
    logic [ADDR_WIDTH-1:0] pc_inc;
    logic [ADDR_WIDTH-1:0] jump_target;
    logic                  restart;

    assign pc_inc      = pc_q + 1'b1;                 // wraps naturally
    assign jump_target = instr_q[ADDR_WIDTH-1:0];     // truncated operand
    // start only counts when nothing is executing
    assign restart     = start && (state_q == ST_IDLE || state_q == ST_HALTED);

`ifdef SEQ_CALL_STACK_EN
    logic                  fault_q, fault_d;
    logic                  stk_push, stk_pop, stk_clear, stk_full, stk_empty;
    logic [ADDR_WIDTH-1:0] stk_top;

    seq_return_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (ADDR_WIDTH)
    ) u_return_stack (
        .clk       (clk),
        .reset     (reset),
        .clear     (stk_clear),
        .push      (stk_push),
        .pop       (stk_pop),
        .push_data (pc_inc),
        .top_data  (stk_top),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
`ifdef SEQ_CALL_STACK_EN
        fault_d   = fault_q;
        stk_push  = 1'b0;
        stk_pop   = 1'b0;
        stk_clear = restart;
        if (restart) fault_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE, ST_HALTED: begin
                if (restart) begin
                    state_d = ST_FETCH;
                    pc_d    = START_PC;
                end
            end
            ST_FETCH: begin
                if (mem_ack) begin
                    instr_d = mem_rdata;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (instr_class(instr_q))
                    NOP_CLASS: begin
                        pc_d    = pc_inc;
                        state_d = ST_FETCH;
                    end
                    HALT_OP: state_d = ST_HALTED;  // pc stays on the halt
                    BR_OP: begin
                        pc_d    = branch_taken(instr_q[19:16], alu_flags)
                                  ? jump_target : pc_inc;
                        state_d = ST_FETCH;
                    end
                    CALL_OP: begin
`ifdef SEQ_CALL_STACK_EN
                        if (stk_full) begin
                            fault_d = 1'b1;
                            state_d = ST_HALTED;
                        end else begin
                            stk_push = 1'b1;
                            pc_d     = jump_target;
                            state_d  = ST_FETCH;
                        end
`else
                        pc_d    = pc_inc;
                        state_d = ST_FETCH;
`endif
                    end
                    RET_OP: begin
`ifdef SEQ_CALL_STACK_EN
                        if (stk_empty) begin
                            fault_d = 1'b1;
                            state_d = ST_HALTED;
                        end else begin
                            stk_pop = 1'b1;
                            pc_d    = stk_top;
                            state_d = ST_FETCH;
                        end
`else
                        pc_d    = pc_inc;
                        state_d = ST_FETCH;
`endif
                    end
                    ALU_OP:  state_d = ST_ISSUE;
                    default: state_d = ST_ISSUE;   // register ops
                endcase
            end
            ST_ISSUE: begin
                pc_d    = pc_inc;
                state_d = ST_FETCH;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            pc_q    <= START_PC;
            instr_q <= '0;
`ifdef SEQ_CALL_STACK_EN
            fault_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
`ifdef SEQ_CALL_STACK_EN
            fault_q <= fault_d;
`endif
        end
    end

    // Outputs decode straight from the state flop so reset drops them at once.
    assign mem_req     = (state_q == ST_FETCH);
    assign mem_addr    = pc_q;
    assign issue_valid = (state_q == ST_ISSUE);
    assign operator    = issue_valid ? instr_operator(instr_q) : NOP_OP;
    assign operand     = issue_valid ? instr_operand(instr_q) : 16'h0000;
    assign pc          = pc_q;
    assign busy        = (state_q == ST_FETCH) || (state_q == ST_DECODE) ||
                         (state_q == ST_ISSUE);
    assign halted      = (state_q == ST_HALTED);
    assign state_dbg   = state_q;

endmodule

// File: doc/instruction_sequencer.md
Name: instruction_sequencer

Overview:
- Upstream stage of alu_register_verilog: fetches 32-bit instruction words from program memory and issues one operator/operand pair per instruction to the ALU/register stage.
- Consumes the stage's alu_flags for conditional branches; owns the program counter, halt and restart.
- Sits between program memory (req/ack interface) and alu_register_verilog.

Parameters:
ADDR_WIDTH, 8, program counter / memory address width
START_ADDR, 0, PC value loaded on reset and on every start
STACK_DEPTH, 4, return-stack entries (used only with SEQ_CALL_STACK_EN)

Ports:
clk  in  1  clock
reset  in  1  asynchronous reset, active-low
start  in  1  one-cycle pulse; begins execution at START_ADDR from IDLE or HALTED
mem_req  out  1  fetch request
mem_addr  out  ADDR_WIDTH  fetch address (equals pc while mem_req=1)
mem_ack  in  1  fetch complete; mem_rdata valid this cycle
mem_rdata  in  32  instruction: [31:16] operator, [15:0] operand
operator  out  16  to alu_register_verilog operator
operand  out  16  to alu_register_verilog operand
issue_valid  out  1  operator/operand carry a real instruction this cycle
alu_flags  in  4  flags from alu_register_verilog
pc  out  ADDR_WIDTH  current program counter
busy  out  1  high in FETCH/DECODE/ISSUE
halted  out  1  high in HALTED
fault  out  1  sticky stack error; cleared by start or reset

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, pc=START_ADDR, mem_req=0, issue_valid=0, operator=NOP_OP (16'hF000), operand=0, busy=0, halted=0, fault=0. A mid-fetch reset drops mem_req immediately; a late mem_ack is ignored.
- Opcode classes use operator[15:12]: 4'h1 ALU; 4'hB branch; 4'hC call; 4'hD return; 4'hE halt; 4'hF NOP; all others are register ops, forwarded like ALU.
- States:
  - IDLE: outputs idle. start -> FETCH, pc=START_ADDR.
  - FETCH: mem_req=1, mem_addr=pc. Holds until mem_ack=1; on that edge, latch mem_rdata -> DECODE. Zero-wait acks (ack in the first FETCH cycle) are legal.
  - DECODE: one cycle, no issue.
    - ALU/register op -> ISSUE.
    - NOP -> pc=pc+1 -> FETCH.
    - Halt -> HALTED; pc is not advanced.
    - Branch: mask=operator[3:0]. Taken if mask==0 or (alu_flags & mask)!=0. Taken loads pc=operand[ADDR_WIDTH-1:0]; otherwise pc=pc+1. -> FETCH.
  - ISSUE: exactly one cycle. issue_valid=1, operator/operand = latched word. pc=pc+1 -> FETCH.
  - HALTED: halted=1. start -> FETCH, pc=START_ADDR, fault cleared.
- Outside ISSUE, operator=NOP_OP, operand=0 and issue_valid=0.
- Minimum latency: 3 cycles per issued instruction (FETCH with zero-wait ack, DECODE, ISSUE).
- Flags sampled in DECODE always reflect the most recent issued op, because DECODE is at least 2 cycles after any ISSUE.
- pc+1 wraps modulo 2^ADDR_WIDTH. Branch and call targets are truncated to ADDR_WIDTH bits.
- start while busy is ignored.
- Reset asserted simultaneously with start: reset wins.

Optional Feature:
SEQ_CALL_STACK_EN
- Defined: STACK_DEPTH-entry return stack.
  - Call (4'hC) pushes pc+1 and jumps to operand.
  - Return (4'hD) pops into pc.
  - Push when full, or pop when empty: fault=1, state -> HALTED, stack unchanged.
  - Stack is cleared on reset and start.
- Undefined: 4'hC and 4'hD decode as NOP; fault is tied to 0; no stack storage.

Decomposition:
- Shared package: opcode class constants (ALU_OP 4'h1, BR_OP 4'hB, CALL_OP 4'hC, RET_OP 4'hD, HALT_OP 4'hE, NOP_CLASS 4'hF), NOP_OP 16'hF000, state encoding, instruction field positions.
- One sub-module: seq_return_stack (push/pop/full/empty, depth parameter), instantiated only under SEQ_CALL_STACK_EN.

Test Plan:
- Reset and idle: reset=0 mid-FETCH -> mem_req=0 immediately; after release, pc=0, operator=16'hF000, issue_valid=0.
- Straight-line program: words 0x1301_0200, 0x1402_0100, halt 0xE000_0000, zero-wait ack -> issue_valid pulses every 3 cycles with the exact operator/operand; halted=1 with pc=2.
- Branch: flags=4'b0001, branch 0xB001_0005 -> pc=5. With flags=0 -> pc=pc+1. With mask 0 -> always taken.
- Wait states: mem_ack delayed by 4 cycles -> mem_req and mem_addr held stable, no issue, correct word latched. PC wrap at 8'hFF -> next fetch at 0.
- Call stack (macro on): nested calls to depth 4 followed by returns -> correct return addresses. A 5th call -> fault=1, halted=1. Return on empty -> fault=1.
- Restart: start in HALTED -> fetch from START_ADDR, fault cleared. Start while busy -> no effect.
